// File: rtl/reaction_if.sv
// ============================================================================
// Module      : reaction_if
// Description : Signal bundle between the lights sequencer and the
//               reaction_capture block. BEST_TIME_EN adds best_time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reaction_if #(
  parameter int WIDTH = 14
);
  logic             tick_ms;
  logic             arm;
  logic             lights_out;
  logic             key_n;
  logic [WIDTH-1:0] reaction_time;
  logic             valid;
  logic             false_start;
  logic             timed_out;
  logic             busy;
`ifdef BEST_TIME_EN
  logic [WIDTH-1:0] best_time;

  modport master (
    output tick_ms, arm, lights_out, key_n,
    input  reaction_time, valid, false_start, timed_out, busy, best_time
  );

  modport slave (
    input  tick_ms, arm, lights_out, key_n,
    output reaction_time, valid, false_start, timed_out, busy, best_time
  );
`else
  modport master (
    output tick_ms, arm, lights_out, key_n,
    input  reaction_time, valid, false_start, timed_out, busy
  );

  modport slave (
    input  tick_ms, arm, lights_out, key_n,
    output reaction_time, valid, false_start, timed_out, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/reaction_capture.sv
// ============================================================================
// Module      : reaction_capture
// Description : Debounces the REACT key and times it against lights-out,
//               flagging false starts and timeouts. BEST_TIME_EN adds a
//               running minimum of valid reaction times (best_time).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reaction_capture #(
  parameter int WIDTH       = 14,
  parameter int DEBOUNCE_MS = 10,
  parameter int TIMEOUT     = 9999
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  reaction_if.slave  bus
);

  localparam int               c_DB_W       = $clog2(DEBOUNCE_MS + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DEBOUNCE_MS - 1);
  localparam logic [WIDTH-1:0]  c_TIMEOUT   = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0]  c_TIMEOUT_M1 = WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_TIMING = 3'd2,
    S_DONE   = 3'd3,
    S_FALSE  = 3'd4,
    S_TOUT   = 3'd5
  } state_t;

  // Key conditioning
  logic              r_sync1;
  logic              r_sync2;
  logic              r_db_level;
  logic [c_DB_W-1:0] r_db_cnt;
  logic              r_press;
  logic              w_db_flip;

  assign w_db_flip = bus.tick_ms && (r_sync2 != r_db_level) && (r_db_cnt == c_DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_sync1 <= ~bus.key_n;
      r_sync2 <= r_sync1;
      r_press <= w_db_flip && !r_db_level;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (bus.tick_ms) begin
        if (r_db_cnt == c_DB_LAST) begin
          r_db_cnt   <= '0;
          r_db_level <= ~r_db_level;
        end else begin
          r_db_cnt <= r_db_cnt + c_DB_W'(1);
        end
      end
    end
  end

  // Round FSM and result registers
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_rt;
  logic [WIDTH-1:0] w_rt_nxt;
  logic             r_fs;
  logic             w_fs_nxt;
  logic             r_to;
  logic             w_to_nxt;
  logic             r_valid;
  logic             w_valid_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_rt    <= '0;
      r_fs    <= 1'b0;
      r_to    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_rt    <= w_rt_nxt;
      r_fs    <= w_fs_nxt;
      r_to    <= w_to_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_rt_nxt    = r_rt;
    w_fs_nxt    = r_fs;
    w_to_nxt    = r_to;
    w_valid_nxt = 1'b0;
    if (bus.arm) begin
      w_state_nxt = S_ARMED;
      w_count_nxt = '0;
      w_rt_nxt    = '0;
      w_fs_nxt    = 1'b0;
      w_to_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (r_press) begin
            w_state_nxt = S_FALSE;
            w_fs_nxt    = 1'b1;
          end else if (bus.lights_out) begin
            w_state_nxt = S_TIMING;
            w_count_nxt = '0;
          end
        end
        S_TIMING: begin
          // A press wins over a coincident tick, so the pre-tick count is reported
          if (r_press) begin
            w_state_nxt = S_DONE;
            w_rt_nxt    = r_count;
            w_valid_nxt = 1'b1;
          end else if (bus.tick_ms) begin
            if (r_count == c_TIMEOUT_M1) begin
              w_state_nxt = S_TOUT;
              w_count_nxt = c_TIMEOUT;
              w_rt_nxt    = c_TIMEOUT;
              w_to_nxt    = 1'b1;
            end else begin
              w_count_nxt = r_count + WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.reaction_time = r_rt;
  assign bus.valid         = r_valid;
  assign bus.false_start   = r_fs;
  assign bus.timed_out     = r_to;
  assign bus.busy          = (r_state == S_ARMED) || (r_state == S_TIMING);

`ifdef BEST_TIME_EN
  logic [WIDTH-1:0] r_best;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best <= '1;
    end else if (w_valid_nxt && (w_rt_nxt < r_best)) begin
      r_best <= w_rt_nxt;
    end
  end

  assign bus.best_time = r_best;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reaction_capture.sv
// ============================================================================
// Module      : tb_reaction_capture
// Description : Self-checking bench for reaction_capture; rounds are scripted
//               on a millisecond timeline and scored by a ms-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reaction_capture;

  localparam int WIDTH       = 14;
  localparam int DEBOUNCE_MS = 10;
  localparam int TIMEOUT     = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  reaction_if #(.WIDTH(WIDTH)) bus();

  reaction_capture #(
    .WIDTH       (WIDTH),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int valid_cnt = 0;
  logic [WIDTH-1:0] best_exp = '1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) valid_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic ms();
    bus.tick_ms = 1'b1;
    @(negedge clk) bus.tick_ms = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_ms(input int n);
    repeat (n) ms();
  endtask

  task automatic tick_only();
    bus.tick_ms = 1'b1;
    @(negedge clk) bus.tick_ms = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    @(negedge clk) bus.arm = 1'b0;
  endtask

  task automatic pulse_lo();
    bus.lights_out = 1'b1;
    @(negedge clk) bus.lights_out = 1'b0;
  endtask

  // Two settle cycles so the synchronised level is stable before the next tick
  task automatic key_set(input logic v);
    bus.key_n = v;
    repeat (2) @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic release_key();
    key_set(1'b1);
    run_ms(DEBOUNCE_MS + 2);
  endtask

  task automatic check_best(input string tag);
`ifdef BEST_TIME_EN
    check_eq({tag, ".best"}, bus.best_time, best_exp);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One round: arm at slot 0, lights_out at slot L, debounced press after tick P
  // (P < 0: no press). Each slot applies its events, then one tick.
  task automatic round(input string tag, input int L, input int P, input bit bounce);
    int K, rt_e, val_e, fs_e, to_e, last, v0;
    K = (P >= 0) ? P - DEBOUNCE_MS + 1 : -1;
    rt_e = 0; val_e = 0; fs_e = 0; to_e = 0;
    if (P < 0) begin
      rt_e = TIMEOUT; to_e = 1; last = L + TIMEOUT + 2;
    end else if (P < L) begin
      fs_e = 1; last = L + 3;
    end else if (P - L + 1 < TIMEOUT) begin
      rt_e = P - L + 1; val_e = 1; last = P + 2;
    end else begin
      rt_e = TIMEOUT; to_e = 1;
      last = ((P > L + TIMEOUT) ? P : L + TIMEOUT) + 2;
    end
    v0 = valid_cnt;
    for (int m = 0; m <= last; m++) begin
      if (m == 0) begin
        pulse_arm();
        check_eq({tag, ".arm_busy"}, bus.busy, 1);
        check_eq({tag, ".arm_rt"}, bus.reaction_time, 0);
      end
      if (m == L) pulse_lo();
      if (K >= 0) begin
        if (bounce && (m == K - 8 || m == K - 4)) key_set(1'b0);
        if (bounce && (m == K - 6 || m == K - 2)) key_set(1'b1);
        if (m == K) key_set(1'b0);
      end
      ms();
    end
    settle();
    check_eq({tag, ".rt"}, bus.reaction_time, rt_e);
    check_eq({tag, ".valids"}, valid_cnt - v0, val_e);
    check_eq({tag, ".false_start"}, bus.false_start, fs_e);
    check_eq({tag, ".timed_out"}, bus.timed_out, to_e);
    check_eq({tag, ".busy"}, bus.busy, 0);
    if (val_e != 0 && rt_e < int'(best_exp)) best_exp = WIDTH'(rt_e);
    check_best(tag);
    if (K >= 0) release_key();
  endtask

  initial begin
    int v0, L, P, K, mode;
    bit bounce;
    bus.tick_ms    = 1'b0;
    bus.arm        = 1'b0;
    bus.lights_out = 1'b0;
    bus.key_n      = 1'b1;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset.rt", bus.reaction_time, 0);
    check_eq("reset.valid", bus.valid, 0);
    check_eq("reset.false_start", bus.false_start, 0);
    check_eq("reset.timed_out", bus.timed_out, 0);
    check_eq("reset.busy", bus.busy, 0);
    check_best("reset");
    rst_n = 1'b1;
    @(negedge clk);

    round("normal237", 5, 5 + 237 - 1, 1'b0);
    round("false50", 80, 50 + DEBOUNCE_MS - 1, 1'b0);
    round("timeout", 7, -1, 1'b0);
    round("bounce", 4, 4 + 40 - 1, 1'b1);

    // Press pulse coincides with lights_out
    v0 = valid_cnt;
    pulse_arm();
    key_set(1'b0);
    run_ms(DEBOUNCE_MS - 1);
    tick_only();
    pulse_lo();
    run_ms(3);
    settle();
    check_eq("press_lo.false_start", bus.false_start, 1);
    check_eq("press_lo.rt", bus.reaction_time, 0);
    check_eq("press_lo.valids", valid_cnt - v0, 0);
    release_key();

    // arm with lights_out in the same cycle stays ARMED
    v0 = valid_cnt;
    bus.arm = 1'b1;
    bus.lights_out = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
    bus.lights_out = 1'b0;
    run_ms(5);
    check_eq("arm_lo.busy", bus.busy, 1);
    pulse_lo();
    key_set(1'b0);
    run_ms(DEBOUNCE_MS);
    settle();
    check_eq("arm_lo.rt", bus.reaction_time, DEBOUNCE_MS);
    check_eq("arm_lo.valids", valid_cnt - v0, 1);
    if (DEBOUNCE_MS < int'(best_exp)) best_exp = WIDTH'(DEBOUNCE_MS);
    release_key();

    // Press pulse coincides with the tick that would reach TIMEOUT
    v0 = valid_cnt;
    pulse_arm();
    pulse_lo();
    run_ms(TIMEOUT - DEBOUNCE_MS - 1);
    key_set(1'b0);
    run_ms(DEBOUNCE_MS - 1);
    bus.tick_ms = 1'b1;
    repeat (2) @(negedge clk);
    bus.tick_ms = 1'b0;
    @(negedge clk);
    run_ms(2);
    settle();
    check_eq("tout_edge.rt", bus.reaction_time, TIMEOUT - 1);
    check_eq("tout_edge.valids", valid_cnt - v0, 1);
    check_eq("tout_edge.timed_out", bus.timed_out, 0);
    release_key();

    // Key held across arm gives no false start
    key_set(1'b0);
    run_ms(DEBOUNCE_MS + 2);
    v0 = valid_cnt;
    pulse_arm();
    pulse_lo();
    run_ms(30);
    settle();
    check_eq("held.false_start", bus.false_start, 0);
    check_eq("held.busy", bus.busy, 1);
    check_eq("held.valids_early", valid_cnt - v0, 0);
    key_set(1'b1);
    run_ms(DEBOUNCE_MS);
    key_set(1'b0);
    run_ms(DEBOUNCE_MS);
    settle();
    check_eq("held.rt", bus.reaction_time, 30 + 2 * DEBOUNCE_MS);
    check_eq("held.valids", valid_cnt - v0, 1);
    release_key();

    // Asynchronous reset in the middle of timing
    v0 = valid_cnt;
    pulse_arm();
    pulse_lo();
    run_ms(100);
    check_eq("rst_mid.busy_before", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid.busy", bus.busy, 0);
    check_eq("rst_mid.rt", bus.reaction_time, 0);
    check_eq("rst_mid.valid", bus.valid, 0);
    check_eq("rst_mid.false_start", bus.false_start, 0);
    check_eq("rst_mid.timed_out", bus.timed_out, 0);
    best_exp = '1;
    check_best("rst_mid");
    @(negedge clk) rst_n = 1'b1;
    settle();
    check_eq("rst_mid.valids", valid_cnt - v0, 0);

    round("best300", 3, 3 + 300 - 1, 1'b0);
    round("best180", 3, 3 + 180 - 1, 1'b0);
    round("best250", 3, 3 + 250 - 1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      mode   = $urandom_range(0, 9);
      L      = $urandom_range(DEBOUNCE_MS, 60);
      if (mode < 2) begin
        P = -1;
      end else if (mode < 4) begin
        K = $urandom_range(0, L - DEBOUNCE_MS);
        P = K + DEBOUNCE_MS - 1;
      end else begin
        P = L + $urandom_range(1, TIMEOUT + 3) - 1;
      end
      K      = (P >= 0) ? P - DEBOUNCE_MS + 1 : -1;
      bounce = (K >= 8) && ($urandom_range(0, 1) == 1);
      round($sformatf("rand%0d", i), L, P, bounce);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
